// File: rtl/prng_pkg.sv
// Shared types and helpers for the PRNG range-reduction block.
package prng_pkg;

    // The LCG state is 31 bits wide, so bit 30 is its strongest output bit.
    localparam int LCG_MSB = 30;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } prng_range_state_t;

    // Smallest 2^k-1 covering bound-1; all ones of 'width' bits when bound is 0.
    function automatic logic [31:0] mask_for_bound(input logic [31:0] bound, input int width);
        logic [31:0] m;
        if (bound == 32'd0) begin
            m = (32'd1 << width) - 32'd1;
        end else begin
            m = '0;
            for (int i = 0; i < 32; i++) begin
                if (m < bound - 32'd1) m = {m[30:0], 1'b1};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/prng_sync_fifo.sv
// Generic synchronous FIFO with head peek and occupancy count.
module prng_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // Pop on empty is ignored; push on full only succeeds alongside a pop.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count < CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/prng_range.sv
// Mask-and-reject range reduction of raw LCG words into [0, bound), buffered by a FIFO.
// Optional PRNG_RANGE_STATS_EN adds saturating accept/reject counters.
module prng_range
    import prng_pkg::*;
#(
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] bound,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PRNG_RANGE_STATS_EN
    ,
    output logic [15:0]      rej_count,
    output logic [15:0]      acc_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    prng_range_state_t r_state;
    prng_range_state_t w_next;

    logic [OUT_W-1:0] r_bound_q;
    logic [OUT_W-1:0] r_mask_q;
    logic [OUT_W-1:0] r_cand_p1;
    logic             r_vld_p1;

    logic [31:0]      w_mask_wide;
    logic             w_unused_bits;
    logic             w_bound_chg;
    logic             w_flush;
    logic [CW:0]      w_occ;
    logic             w_xfer;
    logic             w_in_range;
    logic             w_accept;
    logic             w_reject;
    logic             w_push;
    logic             w_pop;
    logic [OUT_W-1:0] w_head;
    logic [CW-1:0]    w_count;

    assign w_mask_wide   = mask_for_bound(32'(bound), OUT_W);
    assign w_unused_bits = ^{in_data, w_mask_wide[31:OUT_W]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= FLUSH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FLUSH:   w_next = RUN;
            RUN:     if (w_bound_chg) w_next = FLUSH;
            default: w_next = FLUSH;
        endcase
    end

    // A bound change empties the FIFO on the same edge it enters FLUSH, so FLUSH shows no output.
    assign w_bound_chg = (bound != r_bound_q);
    assign w_flush     = (r_state == FLUSH) || w_bound_chg;

    // Occupancy counts the in-flight candidate so an accepted word always has a slot.
    assign w_occ    = {1'b0, w_count} + (CW + 1)'(r_vld_p1);
    assign in_ready = (r_state == RUN) && !w_bound_chg && (w_occ < (CW + 1)'(FIFO_DEPTH));
    assign w_xfer   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bound_q <= '0;
            r_mask_q  <= '0;
        end else if (r_state == FLUSH) begin
            r_bound_q <= bound;
            r_mask_q  <= w_mask_wide[OUT_W-1:0];
        end
    end

    // Stage 1: slice the strongest state bits and mask to the bound's power-of-two range
    always_ff @(posedge clk) begin
        if (rst || w_flush) r_vld_p1 <= 1'b0;
        else                r_vld_p1 <= w_xfer;
    end

    always_ff @(posedge clk) begin
        if (w_xfer) r_cand_p1 <= in_data[LCG_MSB -: OUT_W] & r_mask_q;
    end

    // Stage 2: accept/reject against bound_q and push into the FIFO
    assign w_in_range = (r_bound_q == '0) || (r_cand_p1 < r_bound_q);
    assign w_accept   = r_vld_p1 && w_in_range;
    assign w_reject   = r_vld_p1 && !w_in_range;
    assign w_push     = w_accept && !w_flush;
    assign w_pop      = out_valid && out_ready;

    prng_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_flush),
        .i_push  (w_push),
        .i_data  (r_cand_p1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_data  = out_valid ? w_head : '0;

`ifdef PRNG_RANGE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || r_state == FLUSH) begin
            acc_count <= '0;
            rej_count <= '0;
        end else if (!w_flush) begin
            if (w_accept) acc_count <= sat_inc(acc_count);
            if (w_reject) rej_count <= sat_inc(rej_count);
        end
    end
`endif

endmodule

// File: tb/tb_prng_range.sv
// Directed scoreboard bench for prng_range (OUT_W=8, FIFO_DEPTH=4).
module tb_prng_range;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bound;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef PRNG_RANGE_STATS_EN
    logic [15:0] rej_count;
    logic [15:0] acc_count;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    prng_range #(.OUT_W(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bound     (bound),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PRNG_RANGE_STATS_EN
        ,
        .rej_count (rej_count),
        .acc_count (acc_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake pops the oldest expected sample.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0h expected no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_exp));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one word with sample bits [30:23]=smp; bit 31 and low bits are noise.
    task automatic send(input logic [7:0] smp, input bit acc, input logic [7:0] ev);
        int g;
        g = 0;
        in_data  = {1'b1, smp, 23'h2A5A5};
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
        end else if (acc) begin
            exp_q.push_back(ev);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 60) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d samples outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        bound     = 8'd10;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("flush_after_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("run_in_ready", 32'(in_ready), 32'd1);
        tick();

        // bound 10, mask 0x0F, with two-cycle latency check on the first sample
        send(8'h05, 1'b1, 8'd5);
        @(negedge clk);
        chk("lat_n1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_n2_out_valid", 32'(out_valid), 32'd1);
        tick();
        send(8'h0C, 1'b0, 8'd0);
        send(8'hF3, 1'b1, 8'd3);
        drain("drain_b10");

        // bound 0: full 8-bit range, everything accepted
        bound = 8'd0;
        send(8'hFF, 1'b1, 8'hFF);
        send(8'h00, 1'b1, 8'h00);
        send(8'h80, 1'b1, 8'h80);
        drain("drain_b0");

        // bound 1: mask 0, every sample is 0
        bound = 8'd1;
        send(8'hAB, 1'b1, 8'd0);
        send(8'h37, 1'b1, 8'd0);
        send(8'hFF, 1'b1, 8'd0);
        drain("drain_b1");
`ifdef PRNG_RANGE_STATS_EN
        chk("stats_acc_b1", 32'(acc_count), 32'd3);
        chk("stats_rej_b1", 32'(rej_count), 32'd0);
`endif

        // backpressure: only four samples fit, including the in-flight candidate
        out_ready = 1'b0;
        bound     = 8'd10;
        send(8'h01, 1'b1, 8'd1);
        send(8'h02, 1'b1, 8'd2);
        send(8'h03, 1'b1, 8'd3);
        send(8'h04, 1'b1, 8'd4);
        in_data  = {1'b1, 8'h05, 23'h2A5A5};
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready),  32'd0);
        chk("bp_out_valid",    32'(out_valid), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("drain_bp");

        // bound change 10 -> 6 with three samples buffered
        out_ready = 1'b0;
        send(8'h02, 1'b1, 8'd2);
        send(8'h05, 1'b1, 8'd5);
        send(8'h09, 1'b1, 8'd9);
        tick();
        tick();
        exp_q.delete();
        bound = 8'd6;
        @(negedge clk);
        @(negedge clk);
        chk("flush_in_ready",  32'(in_ready),  32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        tick();
        out_ready = 1'b1;
        send(8'h03, 1'b1, 8'd3);
        send(8'h0E, 1'b0, 8'd0);
        send(8'h0D, 1'b1, 8'd5);
        send(8'h07, 1'b0, 8'd0);
        send(8'h00, 1'b1, 8'd0);
        drain("drain_b6");

        // reset mid-operation with buffered samples and a stage-1 candidate
        out_ready = 1'b0;
        send(8'h01, 1'b0, 8'd0);
        send(8'h02, 1'b0, 8'd0);
        send(8'h03, 1'b0, 8'd0);
        send(8'h04, 1'b0, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        chk("midrst_run_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_run_out_valid", 32'(out_valid), 32'd0);
        tick();
        out_ready = 1'b1;
        send(8'h02, 1'b1, 8'd2);
        drain("drain_midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prng_range.md
Name: prng_range

Overview:
- Downstream stage of the LCG PRNG. Consumes raw 32-bit LCG words and produces uniformly distributed values in [0, bound) by mask-and-reject sampling.
- Accepted samples are buffered in a small FIFO and presented on a valid/ready interface to consumers such as dice, shufflers and test-pattern generators.
- The PRNG state is 31 bits (mod 2^31), and its upper bits are the strongest, so samples are drawn from in_data[30:31-OUT_W].

Parameters:
- OUT_W, 8, output sample width; legal range 1..31.
- FIFO_DEPTH, 4, accepted-sample buffer depth; power of two, 2..16.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  32  raw PRNG word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- bound  input  OUT_W  exclusive upper limit; 0 means full range 2^OUT_W.
- out_data  output  OUT_W  sample, valid when out_valid is high.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer takes out_data this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0, out_valid=0, out_data=0, FIFO empty, stage-1 valid=0, bound_q=0, state=FLUSH.
- FSM states:
  - FLUSH (1 cycle): clear FIFO pointers and count; drop stage-1 candidate; bound_q<=bound; mask_q<=2^ceil(log2(bound))-1 (all ones if bound=0; 0 if bound=1). Next state RUN.
  - RUN: normal operation. If bound != bound_q in any cycle, next state FLUSH. Samples pending that cycle are discarded, including any handshake completing in that cycle.
- Input handshake: transfer when in_valid && in_ready.
  - in_ready = (state==RUN) && (bound==bound_q) && (count + stage1_valid < FIFO_DEPTH).
  - This reserves a FIFO slot for the in-flight candidate, so no accepted word is ever dropped for lack of space.
- Stage 1: on transfer, cand_q <= in_data[30:31-OUT_W] & mask_q, and stage1_valid<=1; otherwise stage1_valid<=0.
- Stage 2 (same cycle as stage-1 output):
  - Accept if stage1_valid && (bound_q==0 || cand_q < bound_q).
  - Accepted samples are written to the FIFO at the tail. Rejected samples are discarded.
- Output: out_valid = count!=0; out_data = FIFO head. Pop when out_valid && out_ready.
- Latency: transfer in cycle N -> out_valid high in cycle N+2 if the FIFO was empty and the sample was accepted.
- Simultaneous push and pop:
  - Allowed at any count, including full-with-pop; count unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Arithmetic:
  - Comparison is unsigned, OUT_W bits.
  - mask_q width is OUT_W.
  - Count width is $clog2(FIFO_DEPTH)+1.
- Reset mid-operation discards all FIFO contents and candidates next cycle; there is no partial output.
- Ordering: out_data order equals acceptance order.

Optional Feature:
- PRNG_RANGE_STATS_EN defined:
  - Adds outputs rej_count[15:0] and acc_count[15:0], saturating at 0xFFFF.
  - Both counters increment on a stage-2 reject or accept, respectively.
  - Both are cleared by rst and by FLUSH.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package prng_pkg:
  - typedef enum logic {FLUSH, RUN} prng_range_state_t.
  - Function mask_for_bound(bound, width) returning the all-ones mask.
  - Constant LCG_MSB=30, documenting the state width.
- Sub-module prng_sync_fifo: generic FIFO parameterised by width and depth, with push/pop/count/head and synchronous active-high rst; reusable elsewhere.

Test Plan:
- Bound 10, OUT_W=8, mask 0x0F, out_ready=1:
  - in_data bits[30:23]=0x05 -> out_data=5 two cycles later.
  - bits[30:23]=0x0C -> no output.
  - bits[30:23]=0xF3 (masked to 3) -> out_data=3.
- bound=0: words with [30:23]=0xFF, 0x00, 0x80 -> outputs 0xFF, 0x00, 0x80, all accepted.
- bound=1: any input stream -> every output is 0 and no rejects occur. With PRNG_RANGE_STATS_EN: rej_count stays 0 and acc_count equals the number of transfers.
- Backpressure: out_ready=0, bound=10, feed accepting words continuously:
  - in_ready drops once count+stage1_valid reaches 4.
  - Exactly 4 samples are held.
  - Raising out_ready drains them in order.
- Bound change with 3 samples buffered, bound 10->6:
  - One FLUSH cycle with in_ready=0, out_valid=0.
  - Subsequent outputs are all <6; no old samples appear.
- Assert rst for 1 cycle with FIFO full and a candidate in stage 1:
  - Next cycle out_valid=0 and in_ready=0, then RUN with an empty FIFO.
